// File: rtl/morra_match_sequencer.sv
// Sequencer for one MorraCinese game core: game start/config, per-manche move
// collection from two independent players, single-cycle issue, result reporting.
module morra_match_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_req,
  input  logic [3:0] start_len,
  output logic       start_ack,
  input  logic       p1_valid,
  input  logic [1:0] p1_move,
  output logic       p1_ready,
  input  logic       p2_valid,
  input  logic [1:0] p2_move,
  output logic       p2_ready,
  output logic       core_inizia,
  output logic [1:0] core_primo,
  output logic [1:0] core_secondo,
  input  logic [1:0] core_manche,
  input  logic [1:0] core_partita,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [1:0] res_manche,
  output logic [1:0] res_partita,
  output logic [4:0] res_index,
  output logic       busy,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CONFIG, S_COLLECT, S_ISSUE, S_CAPTURE, S_REPORT
  } state_t;

  state_t          state;
  logic [1:0]      mv1_q, mv2_q;
  logic [TO_W-1:0] to_cnt;

  logic            take1, take2, got1, got2, expire;
  logic [1:0]      mv1_n, mv2_n;
  logic [TO_W-1:0] to_cnt_inc;

  // pN_ready is only ever high in COLLECT, and low there once N's move is held.
  always_comb begin
    take1      = p1_valid & p1_ready;
    take2      = p2_valid & p2_ready;
    got1       = ~p1_ready | take1;
    got2       = ~p2_ready | take2;
    mv1_n      = take1 ? p1_move : mv1_q;
    mv2_n      = take2 ? p2_move : mv2_q;
    to_cnt_inc = to_cnt + TO_W'(1);
    expire     = (to_cnt_inc == TO_W'(TIMEOUT_CYCLES));
  end

  // Outputs are loaded on the edge that enters a state, so each registered
  // output is valid for exactly the cycles spent in that state.
  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: every register, including the move latches, is reset; the
      // sequencer holds no storage array that could be left unreset.
      state        <= S_IDLE;
      mv1_q        <= 2'b00;
      mv2_q        <= 2'b00;
      to_cnt       <= '0;
      start_ack    <= 1'b0;
      p1_ready     <= 1'b0;
      p2_ready     <= 1'b0;
      core_inizia  <= 1'b0;
      core_primo   <= 2'b00;
      core_secondo <= 2'b00;
      res_valid    <= 1'b0;
      res_manche   <= 2'b00;
      res_partita  <= 2'b00;
      res_index    <= 5'd0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      start_ack    <= 1'b0;
      timeout_err  <= 1'b0;
      core_inizia  <= 1'b0;
      core_primo   <= 2'b00;
      core_secondo <= 2'b00;

      unique case (state)
        S_IDLE: begin
          if (start_req) begin
            start_ack    <= 1'b1;
            core_inizia  <= 1'b1;
            core_primo   <= start_len[3:2];
            core_secondo <= start_len[1:0];
            res_index    <= 5'd0;
            busy         <= 1'b1;
            state        <= S_CONFIG;
          end
        end

        S_CONFIG: begin
          to_cnt   <= '0;
          p1_ready <= 1'b1;
          p2_ready <= 1'b1;
          state    <= S_COLLECT;
        end

        S_COLLECT: begin
          to_cnt <= to_cnt_inc;
          if (expire) begin
            // Abort wins over any transfer landing in the same cycle.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            p1_ready    <= 1'b0;
            p2_ready    <= 1'b0;
            mv1_q       <= 2'b00;
            mv2_q       <= 2'b00;
            state       <= S_IDLE;
          end else begin
            if (take1) begin
              mv1_q    <= p1_move;
              p1_ready <= 1'b0;
            end
            if (take2) begin
              mv2_q    <= p2_move;
              p2_ready <= 1'b0;
            end
            if (got1 && got2) begin
              core_primo   <= mv1_n;
              core_secondo <= mv2_n;
              state        <= S_ISSUE;
            end
          end
        end

        S_ISSUE: begin
          mv1_q <= 2'b00;
          mv2_q <= 2'b00;
          state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          res_manche  <= core_manche;
          res_partita <= core_partita;
          res_index   <= res_index + 5'd1;
          res_valid   <= 1'b1;
          state       <= S_REPORT;
        end

        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (res_partita != 2'b00) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              to_cnt   <= '0;
              p1_ready <= 1'b1;
              p2_ready <= 1'b1;
              state    <= S_COLLECT;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morra_match_sequencer.sv
// Bench for morra_match_sequencer: core stub, protocol-level expectation model
// compared every cycle, plus directed literal checks.
module tb_morra_match_sequencer;
  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_req = 1'b0;
  logic [3:0] start_len = 4'd0;
  logic       start_ack;
  logic       p1_valid = 1'b0;
  logic [1:0] p1_move = 2'b00;
  logic       p1_ready;
  logic       p2_valid = 1'b0;
  logic [1:0] p2_move = 2'b00;
  logic       p2_ready;
  logic       core_inizia;
  logic [1:0] core_primo, core_secondo;
  logic [1:0] core_manche = 2'b00;
  logic [1:0] core_partita = 2'b00;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [1:0] res_manche, res_partita;
  logic [4:0] res_index;
  logic       busy, timeout_err;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  morra_match_sequencer #(.TIMEOUT_CYCLES(TO), .TO_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_req(start_req), .start_len(start_len), .start_ack(start_ack),
    .p1_valid(p1_valid), .p1_move(p1_move), .p1_ready(p1_ready),
    .p2_valid(p2_valid), .p2_move(p2_move), .p2_ready(p2_ready),
    .core_inizia(core_inizia), .core_primo(core_primo), .core_secondo(core_secondo),
    .core_manche(core_manche), .core_partita(core_partita),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_manche(res_manche), .res_partita(res_partita), .res_index(res_index),
    .busy(busy), .timeout_err(timeout_err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Morra rules: 01 rock, 10 paper, 11 scissors; 01 = player 1 wins, 10 = player 2.
  function automatic logic [1:0] manche_of(input logic [1:0] a, input logic [1:0] b);
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    if (a == b) return 2'b11;
    if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10))
      return 2'b01;
    return 2'b10;
  endfunction

  // Core stub: samples on the edge, answers the following cycle.
  int stub_end_at = 5;
  int stub_cnt = 0;
  int stub_issues = 0;
  always @(posedge clk) begin
    if (core_inizia) begin
      stub_cnt = 0;
      core_manche  <= 2'b00;
      core_partita <= 2'b00;
    end else if (core_primo != 2'b00 || core_secondo != 2'b00) begin
      stub_cnt++;
      stub_issues++;
      core_manche  <= manche_of(core_primo, core_secondo);
      core_partita <= (stub_cnt == stub_end_at) ? 2'b01 : 2'b00;
    end
  end

  // Expectation model: tracks the game as protocol events (start, moves held,
  // cycles waited, result due) and derives what each output must show.
  bit         e_ack, e_ini, e_busy, e_to, e_r1, e_r2, e_rv;
  logic [1:0] e_pr, e_se, e_rm, e_rp;
  logic [4:0] e_idx;
  bit         m_game, m_cfg, m_coll, m_rep, m_h1, m_h2, m_t1, m_t2;
  int         m_wait, m_after;
  logic [1:0] m_mv1, m_mv2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {e_ack, e_ini, e_busy, e_to, e_r1, e_r2, e_rv} = '0;
      {e_pr, e_se, e_rm, e_rp} = '0;
      e_idx = 5'd0;
      {m_game, m_cfg, m_coll, m_rep, m_h1, m_h2} = '0;
      m_wait = 0; m_after = 0; m_mv1 = 2'b00; m_mv2 = 2'b00;
    end else begin
      e_ack = 1'b0; e_ini = 1'b0; e_pr = 2'b00; e_se = 2'b00; e_to = 1'b0;
      if (!m_game) begin
        if (start_req) begin
          e_ack = 1'b1; e_ini = 1'b1; e_pr = start_len[3:2]; e_se = start_len[1:0];
          e_idx = 5'd0; e_busy = 1'b1; m_game = 1'b1; m_cfg = 1'b1;
        end
      end else if (m_cfg) begin
        m_cfg = 1'b0; m_coll = 1'b1; m_wait = 0; e_r1 = 1'b1; e_r2 = 1'b1;
      end else if (m_coll) begin
        m_t1 = p1_valid && e_r1;
        m_t2 = p2_valid && e_r2;
        m_wait++;
        if (m_wait >= TO) begin
          e_to = 1'b1; e_busy = 1'b0; e_r1 = 1'b0; e_r2 = 1'b0;
          m_h1 = 1'b0; m_h2 = 1'b0; m_coll = 1'b0; m_game = 1'b0;
        end else begin
          if (m_t1) begin m_h1 = 1'b1; m_mv1 = p1_move; e_r1 = 1'b0; end
          if (m_t2) begin m_h2 = 1'b1; m_mv2 = p2_move; e_r2 = 1'b0; end
          if (m_h1 && m_h2) begin
            e_pr = m_mv1; e_se = m_mv2;
            m_h1 = 1'b0; m_h2 = 1'b0; m_coll = 1'b0; m_after = 1;
          end
        end
      end else if (m_after == 1) begin
        m_after = 2;
      end else if (m_after == 2) begin
        m_after = 0; m_rep = 1'b1; e_rv = 1'b1;
        e_idx = e_idx + 5'd1;
        e_rm = manche_of(m_mv1, m_mv2);
        e_rp = (int'(e_idx) == stub_end_at) ? 2'b01 : 2'b00;
      end else if (m_rep && res_ready) begin
        m_rep = 1'b0; e_rv = 1'b0;
        if (e_rp != 2'b00) begin
          m_game = 1'b0; e_busy = 1'b0;
        end else begin
          m_coll = 1'b1; m_wait = 0; e_r1 = 1'b1; e_r2 = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      check("start_ack",    8'(start_ack),    8'(e_ack));
      check("p1_ready",     8'(p1_ready),     8'(e_r1));
      check("p2_ready",     8'(p2_ready),     8'(e_r2));
      check("core_inizia",  8'(core_inizia),  8'(e_ini));
      check("core_primo",   8'(core_primo),   8'(e_pr));
      check("core_secondo", 8'(core_secondo), 8'(e_se));
      check("res_valid",    8'(res_valid),    8'(e_rv));
      check("res_manche",   8'(res_manche),   8'(e_rm));
      check("res_partita",  8'(res_partita),  8'(e_rp));
      check("res_index",    8'(res_index),    8'(e_idx));
      check("busy",         8'(busy),         8'(e_busy));
      check("timeout_err",  8'(timeout_err),  8'(e_to));
    end
  end

  task automatic wait_res();
    int n = 0;
    while (res_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("res_valid_timely", 8'(res_valid), 8'd1);
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  // Both players move in the current COLLECT cycle; result is then consumed.
  task automatic play(input logic [1:0] m1, input logic [1:0] m2,
                      input logic [1:0] exp_manche, input logic [4:0] exp_idx);
    p1_valid = 1'b1; p1_move = m1; p2_valid = 1'b1; p2_move = m2;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    wait_res();
    check("play res_manche", 8'(res_manche), 8'(exp_manche));
    check("play res_index",  8'(res_index),  8'(exp_idx));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int iss0;

  initial begin
    repeat (3) @(negedge clk);
    check("rst busy",        8'(busy),        8'd0);
    check("rst res_valid",   8'(res_valid),   8'd0);
    check("rst core_inizia", 8'(core_inizia), 8'd0);
    check("rst res_index",   8'(res_index),   8'd0);
    check("rst p1_ready",    8'(p1_ready),    8'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Start: game of 1+4 manches
    start_req = 1'b1; start_len = 4'b0001;
    @(negedge clk);
    start_req = 1'b0;
    check("start ack",      8'(start_ack),    8'd1);
    check("cfg inizia",     8'(core_inizia),  8'd1);
    check("cfg primo",      8'(core_primo),   8'd0);
    check("cfg secondo",    8'(core_secondo), 8'd1);
    check("cfg busy",       8'(busy),         8'd1);
    @(negedge clk);
    check("ack one pulse",  8'(start_ack),    8'd0);

    // Same-cycle moves: rock vs paper
    p1_valid = 1'b1; p1_move = 2'b01; p2_valid = 1'b1; p2_move = 2'b10;
    @(negedge clk);
    p1_valid = 1'b0; p2_valid = 1'b0;
    check("issue primo",    8'(core_primo),   8'd1);
    check("issue secondo",  8'(core_secondo), 8'd2);
    @(negedge clk);
    check("issue one cycle", 8'(core_primo),  8'd0);
    check("capture no res", 8'(res_valid),    8'd0);
    @(negedge clk);
    check("res at T+3",     8'(res_valid),    8'd1);
    check("res manche 10",  8'(res_manche),   8'd2);
    check("res index 1",    8'(res_index),    8'd1);
    handshake();

    // Staggered moves, later move ignored while held, stalled report
    @(negedge clk);
    p1_valid = 1'b1; p1_move = 2'b11;
    @(negedge clk);
    p1_move = 2'b01;
    check("p1 held ready low", 8'(p1_ready), 8'd0);
    repeat (3) @(negedge clk);
    p2_valid = 1'b1; p2_move = 2'b10;
    @(negedge clk);
    p2_valid = 1'b0;
    check("stagger primo",   8'(core_primo),   8'd3);
    check("stagger secondo", 8'(core_secondo), 8'd2);
    p1_valid = 1'b1; p2_valid = 1'b1;
    wait_res();
    repeat (4) @(negedge clk);
    check("stall manche",  8'(res_manche), 8'd1);
    check("stall index",   8'(res_index),  8'd2);
    check("stall p2 rdy",  8'(p2_ready),   8'd0);
    p1_valid = 1'b0; p2_valid = 1'b0;
    handshake();

    // Invalid move passes through, tie, then deciding manche
    play(2'b11, 2'b00, 2'b00, 5'd3);
    handshake();
    play(2'b01, 2'b01, 2'b11, 5'd4);
    handshake();
    play(2'b10, 2'b01, 2'b01, 5'd5);
    check("end partita", 8'(res_partita), 8'd1);
    handshake();
    check("end busy", 8'(busy), 8'd0);

    // New game, then inactivity timeout with a discarded same-cycle transfer
    start_req = 1'b1; start_len = 4'b0000;
    @(negedge clk);
    start_req = 1'b0;
    check("restart ack", 8'(start_ack), 8'd1);
    iss0 = stub_issues;
    @(negedge clk);
    @(negedge clk);
    p1_valid = 1'b1; p1_move = 2'b10;
    @(negedge clk);
    p1_valid = 1'b0;
    check("to p1 latched", 8'(p1_ready), 8'd0);
    repeat (5) begin
      check("no early timeout", 8'(timeout_err), 8'd0);
      @(negedge clk);
    end
    check("to 8th cycle busy", 8'(busy), 8'd1);
    p2_valid = 1'b1; p2_move = 2'b01;
    @(negedge clk);
    p2_valid = 1'b0;
    check("timeout pulse", 8'(timeout_err), 8'd1);
    check("timeout busy",  8'(busy),        8'd0);
    check("timeout no issue primo", 8'(core_primo), 8'd0);
    @(negedge clk);
    check("timeout one pulse", 8'(timeout_err), 8'd0);
    check("timeout core idle", 8'(stub_issues - iss0), 8'd0);

    // Ignored start during COLLECT, then reset during REPORT
    start_req = 1'b1; start_len = 4'b0010;
    @(negedge clk);
    start_req = 1'b0;
    check("cfg2 secondo", 8'(core_secondo), 8'd2);
    @(negedge clk);
    start_req = 1'b1;
    p2_valid = 1'b1; p2_move = 2'b11;
    @(negedge clk);
    start_req = 1'b0;
    check("no ack in collect", 8'(start_ack), 8'd0);
    p2_valid = 1'b0;
    p1_valid = 1'b1; p1_move = 2'b01;
    @(negedge clk);
    p1_valid = 1'b0;
    wait_res();
    check("g3 manche", 8'(res_manche), 8'd1);
    check("g3 index",  8'(res_index),  8'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst res_valid", 8'(res_valid),    8'd0);
    check("async rst busy",      8'(busy),         8'd0);
    check("async rst inizia",    8'(core_inizia),  8'd0);
    check("async rst primo",     8'(core_primo),   8'd0);
    check("async rst secondo",   8'(core_secondo), 8'd0);
    check("async rst index",     8'(res_index),    8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_req = 1'b1; start_len = 4'b0011;
    @(negedge clk);
    start_req = 1'b0;
    check("post rst ack",     8'(start_ack),    8'd1);
    check("post rst secondo", 8'(core_secondo), 8'd3);
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
